// File: rtl/data_collector.sv
// data_collector: captures (addr,data) writes into a 16x4 buffer, replays the
// written entries in ascending address order over valid/ready, then clears.
// Ports: clk, rst_n (async, active low); capture ena/addr_in/data_in;
// readout rd_start/rd_ready/rd_valid/rd_addr/rd_data; status busy, done,
// count, checksum, err_dup.
// Optional macro DATA_COLLECTOR_DROP_CNT_EN adds drop_cnt[7:0], a saturating
// count of cycles where ena was high during READOUT.
module data_collector #(
  parameter int AW = 4,
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] data_in,
  input  logic          rd_start,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic [CW-1:0] checksum,
  output logic          err_dup
`ifdef DATA_COLLECTOR_DROP_CNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    IDLE,
    READOUT
  } state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [DEPTH-1:0] valid;
  logic [DW-1:0]    mem [DEPTH];

  logic wr;
  logic adv;

  assign wr  = (state == IDLE) && ena;
  // Empty slots are skipped without waiting for rd_ready.
  assign adv = (state == READOUT) && (!valid[ptr] || rd_ready);

  assign busy     = (state == READOUT);
  assign rd_valid = busy && valid[ptr];
  assign rd_addr  = ptr;
  assign rd_data  = mem[ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[addr_in] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      valid    <= '0;
      count    <= '0;
      checksum <= '0;
      err_dup  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ena) begin
            valid[addr_in] <= 1'b1;
            checksum <= checksum + CW'(data_in);
            if (valid[addr_in]) err_dup <= 1'b1;
            else count <= count + 1'b1;
          end
          // A same-edge write makes the buffer non-empty.
          if (rd_start) begin
            if (count != '0 || ena) begin
              state <= READOUT;
              ptr   <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READOUT: begin
          if (adv) begin
            if (&ptr) begin
              state <= IDLE;
              valid <= '0;
              count <= '0;
              ptr   <= '0;
              done  <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DATA_COLLECTOR_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (busy && ena && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_data_collector.sv
// tb_data_collector: table-driven capture checks plus scoreboarded readout
// beats for data_collector, including stall, drop, empty and reset cases.
module tb_data_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] addr_in = '0;
  logic [3:0] data_in = '0;
  logic       rd_start = 1'b0;
  logic       rd_ready = 1'b0;
  logic       rd_valid;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic       busy;
  logic       done;
  logic [4:0] count;
  logic [7:0] checksum;
  logic       err_dup;
`ifdef DATA_COLLECTOR_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  data_collector dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .addr_in(addr_in),
    .data_in(data_in),
    .rd_start(rd_start),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .count(count),
    .checksum(checksum),
    .err_dup(err_dup)
`ifdef DATA_COLLECTOR_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] d;
    logic [4:0] exp_count;
    logic [7:0] exp_sum;
    logic       exp_dup;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] d;
  } beat_t;

  vec_t  vecs [5];
  beat_t q [$];
  logic [3:0] mmem [16];
  logic       mvalid [16];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    q.delete();
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    ena = 1'b1;
    addr_in = a;
    data_in = d;
    tick();
    ena = 1'b0;
    mmem[a] = d;
    mvalid[a] = 1'b1;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wr(vecs[i].a, vecs[i].d);
      check("vec_count", count, vecs[i].exp_count);
      check("vec_sum", checksum, vecs[i].exp_sum);
      check("vec_dup", err_dup, vecs[i].exp_dup);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    ena = 1'b0;
    rd_start = 1'b0;
    rd_ready = 1'b0;
    #1;
    model_clear();
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic readout(input int stall_addr, input int stall_n,
                         input bit drop);
    int    stalled = 0;
    bit    seen_done = 1'b0;
    beat_t b;
    for (int a = 0; a < 16; a++)
      if (mvalid[a]) q.push_back('{4'(a), mmem[a]});
    rd_start = 1'b1;
    rd_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    if (drop) begin
      ena = 1'b1;
      addr_in = 4'h1;
      data_in = 4'h1;
    end
    for (int i = 0; i < 64; i++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      check("busy_scan", busy, 1);
      rd_ready = 1'b1;
      if (rd_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat: got addr %0h expected none", rd_addr);
        end else begin
          b = q[0];
          check("beat_addr", rd_addr, b.a);
          check("beat_data", rd_data, b.d);
          if (int'(rd_addr) == stall_addr && stalled < stall_n) begin
            stalled++;
            rd_ready = 1'b0;
          end else begin
            void'(q.pop_front());
          end
        end
      end
      tick();
      ena = 1'b0;
    end
    rd_ready = 1'b0;
    check("done_seen", seen_done, 1);
    check("beats_left", q.size(), 0);
    check("stall_cycles", stalled, stall_n);
    check("count_after", count, 0);
    model_clear();
    tick();
    check("done_once", done, 0);
    check("busy_after", busy, 0);
  endtask

  task automatic empty_start();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("empty_done", done, 1);
    check("empty_busy", busy, 0);
    check("empty_valid", rd_valid, 0);
    tick();
    check("empty_done_end", done, 0);
    check("empty_busy_end", busy, 0);
  endtask

  initial begin
    vecs[0] = '{4'h2, 4'h5, 5'd1, 8'h05, 1'b0};
    vecs[1] = '{4'h7, 4'hA, 5'd2, 8'h0F, 1'b0};
    vecs[2] = '{4'hF, 4'h3, 5'd3, 8'h12, 1'b0};
    vecs[3] = '{4'h4, 4'h9, 5'd1, 8'h09, 1'b0};
    vecs[4] = '{4'h4, 4'h6, 5'd1, 8'h0F, 1'b1};
    model_clear();

    #12;
    check("rst_count", count, 0);
    check("rst_sum", checksum, 0);
    check("rst_dup", err_dup, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // three writes, readout with a 5-cycle stall on (2,5) and a dropped ena
    apply(0, 2);
    readout(2, 5, 1'b1);
    check("sum_kept", checksum, 8'h12);
    check("dup_kept", err_dup, 0);
`ifdef DATA_COLLECTOR_DROP_CNT_EN
    check("drop_cnt", drop_cnt, 1);
`endif

    // overwrite of the same address
    do_reset();
    apply(3, 4);
    readout(-1, 0, 1'b0);
    check("dup_sticky", err_dup, 1);

    empty_start();

    // reset in the middle of a readout
    wr(4'h2, 4'h5);
    wr(4'h9, 4'h1);
    rd_start = 1'b1;
    rd_ready = 1'b0;
    tick();
    rd_start = 1'b0;
    tick();
    check("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", rd_valid, 0);
    check("abort_addr", rd_addr, 0);
    check("abort_done", done, 0);
    check("abort_count", count, 0);
    check("abort_sum", checksum, 0);
    model_clear();
    #3 rst_n = 1'b1;
    tick();
    check("abort_no_done", done, 0);
    empty_start();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/data_collector.md
Name: data_collector

Overview:
- Downstream consumer of `data_source`.
- Captures the (address, data) pairs that `data_source` emits while `ena` is high into a 16-entry x 4-bit buffer, tracking which entries have been written.
- On request, replays the written entries in ascending address order over a valid/ready port, then clears itself.
- Also keeps a running checksum and flags duplicate-address writes for bench and board checking.

Parameters:
- AW, 4, address width; buffer depth = 2**AW.
- DW, 4, data width.
- CW, 8, checksum width; arithmetic is modulo 2**CW.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  capture strobe; high marks addr_in/data_in valid this cycle.
- addr_in  input  AW  write address (from data_source addr_out).
- data_in  input  DW  write data (from data_source data_out).
- rd_start  input  1  single-cycle request to begin readout.
- rd_ready  input  1  consumer ready for the current readout beat.
- rd_valid  output  1  readout beat valid.
- rd_addr  output  AW  address of the current beat.
- rd_data  output  DW  stored data of the current beat.
- busy  output  1  high while in READOUT.
- done  output  1  one-cycle pulse when readout completes.
- count  output  AW+1  number of distinct addresses written (0..16).
- checksum  output  CW  sum of all accepted data_in values.
- err_dup  output  1  sticky flag: an already-valid address was rewritten.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, valid bitmap=0, ptr=0, count=0, checksum=0, err_dup=0, done=0.
  - Under reset rd_valid=0, busy=0, rd_addr=0. Buffer contents are don't-care.
  - Reset mid-readout aborts immediately with no done pulse.
- States: IDLE (capturing) and READOUT.
- Capture (IDLE only): on a clk edge with ena=1:
  - mem[addr_in] <= data_in, and valid[addr_in] <= 1.
  - checksum <= checksum + data_in, zero-extended, wrapping mod 2**CW.
  - If valid[addr_in] was 0: count increments.
  - If valid[addr_in] was 1: data is overwritten, count is unchanged, err_dup <= 1.
  - Write latency is one cycle; count and checksum reflect the write on the next cycle.
- ena in READOUT: ignored; no write, no checksum update.
- rd_start in IDLE with count>0:
  - Next state is READOUT with ptr=0.
  - A same-edge ena write is still performed and is included in the readout.
- rd_start in IDLE with count==0 (and no same-edge write): stay in IDLE; done pulses for one cycle on the next cycle.
- rd_start in READOUT: ignored.
- READOUT scan:
  - rd_addr=ptr, rd_data=mem[ptr], rd_valid = valid[ptr]; busy=1.
  - If valid[ptr]=0: ptr advances one address per cycle without presenting a beat.
  - If valid[ptr]=1: ptr advances only on rd_valid && rd_ready. rd_addr/rd_data must hold stable while rd_valid=1 and rd_ready=0.
- Readout end: when ptr==2**AW-1 and that address is consumed or skipped:
  - done=1 for exactly one cycle and state returns to IDLE.
  - valid bitmap and count clear to 0 and ptr wraps to 0.
  - checksum and err_dup are retained; only rst_n clears them.
- Worst-case readout is 16 cycles plus rd_ready stall cycles.
- rd_valid, busy and done are 0 in IDLE except for the done pulses above.

Optional Feature:
- Macro: DATA_COLLECTOR_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt[7:0], reset to 0.
  - Increments on every cycle in READOUT with ena=1, saturating at 255.
  - Cleared only by rst_n.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then ena for 3 cycles with (addr,data)=(2,5),(7,A),(F,3), then rd_start with rd_ready=1:
  - count=3 and checksum=0x12.
  - Beats (2,5),(7,A),(F,3) in order.
  - done pulses once, then count=0.
- Write (4,9) then (4,6):
  - count=1, err_dup=1, checksum=0x0F.
  - Readout yields the single beat (4,6).
- During readout, hold rd_ready=0 for 5 cycles on beat (2,5): rd_valid, rd_addr=2 and rd_data=5 stay constant; ptr does not advance.
- rd_start with an empty buffer: no rd_valid; done=1 on the next cycle only; busy stays 0.
- Assert ena with (1,1) during READOUT:
  - No write; count and checksum unchanged.
  - With DATA_COLLECTOR_DROP_CNT_EN defined, drop_cnt=1.
- Drive rst_n low mid-readout:
  - All outputs return to reset values asynchronously with no done pulse.
  - A subsequent rd_start produces only the immediate done.
